mem_access_unit: RTL and testbench

- Byte-addressed load/store front end between the CPU datapath and the 1024 x 32 word RAM.
- Converts CPU byte addresses into RAM word addresses and sequences RAM control.
- Handles lb/lbu/lh/lhu/lw and sb/sh/sw. Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended.
- Drives the RAM's sel/ld/str/addr/data_in ports and consumes its data_out.

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-organised RAM.
// Sub-word stores are done as read-modify-write; loads are sign/zero-extended.
module mem_access_unit #(
    parameter int ADDR_W      = 10,
    parameter int RANGE_CHECK = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       cpu_rdata,
    output logic              ram_sel,
    output logic              ram_ld,
    output logic              ram_str,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [2:0]        o_dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_RMW_WR = 3'd3;
    localparam logic [2:0] S_WR     = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        r_state;
    logic [ADDR_W+1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [31:0] w_hi;
    logic        w_bad;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // Handshake: req is a one-cycle-valid strobe taken only in IDLE; busy acts as
    // not-ready from the cycle after acceptance through DONE, and done/err mark completion.
    assign w_hi  = cpu_addr >> (ADDR_W + 2);
    assign w_bad = (size == 2'b11)
                 || ((size == 2'b01) && cpu_addr[0])
                 || ((size == 2'b10) && (cpu_addr[1:0] != 2'b00))
                 || ((RANGE_CHECK != 0) && (w_hi != 32'd0));

    always_comb begin
        w_byte = ram_rdata[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = ram_rdata[15:8];
            2'd2:    w_byte = ram_rdata[23:16];
            2'd3:    w_byte = ram_rdata[31:24];
            default: w_byte = ram_rdata[7:0];
        endcase
        w_half = r_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = ram_rdata;
        endcase
    end

    // Replace only the addressed lane of the word captured during RMW_RD.
    always_comb begin
        w_merge = r_buf;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_merge[7:0]   = r_wdata[7:0];
                2'd1:    w_merge[15:8]  = r_wdata[7:0];
                2'd2:    w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata[15:0];
        end else begin
            w_merge[15:0] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_wdata <= 32'd0;
            r_buf   <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_addr  <= cpu_addr[ADDR_W+1:0];
                        r_size  <= size;
                        r_sext  <= sign_ext;
                        r_wdata <= cpu_wdata;
                        r_err   <= w_bad;
                        if (w_bad)
                            r_state <= S_DONE;
                        else if (!we)
                            r_state <= S_LOAD;
                        else if (size == 2'b10)
                            r_state <= S_WR;
                        else
                            r_state <= S_RMW_RD;
                    end
                end
                S_LOAD: begin
                    r_rdata <= w_load;
                    r_state <= S_DONE;
                end
                S_RMW_RD: begin
                    r_buf   <= ram_rdata;
                    r_state <= S_RMW_WR;
                end
                S_RMW_WR: r_state <= S_DONE;
                S_WR:     r_state <= S_DONE;
                S_DONE:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign err         = (r_state == S_DONE) && r_err;
    assign cpu_rdata   = r_rdata;
    assign ram_ld      = (r_state == S_LOAD) || (r_state == S_RMW_RD);
    assign ram_str     = (r_state == S_RMW_WR) || (r_state == S_WR);
    assign ram_sel     = ram_ld || ram_str;
    assign ram_addr    = (r_state == S_IDLE) ? '0 : r_addr[ADDR_W+1:2];
    assign ram_wdata   = (r_state == S_RMW_WR) ? w_merge :
                         (r_state == S_WR)     ? r_wdata : 32'd0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 1024x32 RAM attached.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic        busy, done, err;
    logic [31:0] cpu_rdata;
    logic        ram_sel, ram_ld, ram_str;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    wire  [31:0] ram_rdata;
    logic [2:0]  dbg_state;

    logic [31:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;
    int str_cnt = 0, ld_cnt = 0, sel_cnt = 0, ovl_cnt = 0, done_cnt = 0;
    logic [9:0]  str_addr;
    logic [31:0] str_data;

    mem_access_unit #(.ADDR_W(10), .RANGE_CHECK(1)) dut (
        .clk(clk), .clr(clr), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .busy(busy), .done(done), .err(err),
        .cpu_rdata(cpu_rdata), .ram_sel(ram_sel), .ram_ld(ram_ld), .ram_str(ram_str),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign ram_rdata = ram_ld ? mem[ram_addr] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (ram_sel && ram_str) mem[ram_addr] <= ram_wdata;
    end

    always @(negedge clk) begin
        if (ram_str) begin
            str_cnt++;
            str_addr = ram_addr;
            str_data = ram_wdata;
        end
        if (ram_ld) ld_cnt++;
        if (ram_sel) sel_cnt++;
        if (ram_ld && ram_str) ovl_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic zero_counts();
        str_cnt = 0; ld_cnt = 0; sel_cnt = 0; done_cnt = 0;
    endtask

    // Issues one request, returns edges-to-done (accepting edge counts as 1), err and rdata.
    task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic e, output logic [31:0] rd);
        @(negedge clk);
        zero_counts();
        we = w; size = sz; sign_ext = sx; cpu_addr = a; cpu_wdata = wd; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'h0BAD_0BAD;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        e  = err;
        rd = cpu_rdata;
        @(posedge clk); #1;
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    int          lat;
    logic        e;
    logic [31:0] rd;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_ram_ctl", {29'd0, ram_sel, ram_ld, ram_str}, 32'd0);
        check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // word store then load
        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, e, rd);
        check("sw_lat", lat, 32'd2);
        check("sw_err", {31'd0, e}, 32'd0);
        check("sw_str_cnt", str_cnt, 32'd1);
        check("sw_ld_cnt", ld_cnt, 32'd0);
        check("sw_str_addr", {22'd0, str_addr}, 32'd4);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, lat, e, rd);
        check("lw_lat", lat, 32'd2);
        check("lw_err", {31'd0, e}, 32'd0);
        check("lw_data", rd, 32'hDEAD_BEEF);

        // sub-word read-modify-write
        mem[1] = 32'h1122_3344;
        do_op(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_00AA, lat, e, rd);
        check("sb_lat", lat, 32'd3);
        check("sb_ld_cnt", ld_cnt, 32'd1);
        check("sb_str_cnt", str_cnt, 32'd1);
        check("sb_wdata", str_data, 32'h11AA_3344);
        check("sb_mem", mem[1], 32'h11AA_3344);
        do_op(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234_BEEF, lat, e, rd);
        check("sh_hi_mem", mem[1], 32'hBEEF_3344);
        do_op(1'b1, 2'b01, 1'b0, 32'h4, 32'h1234_5678, lat, e, rd);
        check("sh_lo_mem", mem[1], 32'hBEEF_5678);
        do_op(1'b1, 2'b00, 1'b0, 32'h7, 32'h0000_0099, lat, e, rd);
        check("sb_b3_mem", mem[1], 32'h99EF_5678);

        // load extension
        mem[0] = 32'h8000_F080;
        do_op(1'b0, 2'b00, 1'b1, 32'h0, 32'd0, lat, e, rd);
        check("lb_0", rd, 32'hFFFF_FF80);
        do_op(1'b0, 2'b00, 1'b0, 32'h0, 32'd0, lat, e, rd);
        check("lbu_0", rd, 32'h0000_0080);
        do_op(1'b0, 2'b01, 1'b1, 32'h2, 32'd0, lat, e, rd);
        check("lh_2", rd, 32'hFFFF_8000);
        check("lh_lat", lat, 32'd2);
        do_op(1'b0, 2'b01, 1'b0, 32'h2, 32'd0, lat, e, rd);
        check("lhu_2", rd, 32'h0000_8000);
        do_op(1'b0, 2'b00, 1'b1, 32'h1, 32'd0, lat, e, rd);
        check("lb_1", rd, 32'hFFFF_FFF0);
        do_op(1'b0, 2'b00, 1'b0, 32'h3, 32'd0, lat, e, rd);
        check("lbu_3", rd, 32'h0000_0080);
        do_op(1'b0, 2'b01, 1'b1, 32'h0, 32'd0, lat, e, rd);
        check("lh_0", rd, 32'hFFFF_F080);

        // errors
        do_op(1'b0, 2'b01, 1'b1, 32'h3, 32'd0, lat, e, rd);
        check("err_lh_lat", lat, 32'd1);
        check("err_lh_err", {31'd0, e}, 32'd1);
        check("err_lh_sel", sel_cnt, 32'd0);
        check("err_lh_rdata", rd, 32'hFFFF_F080);
        do_op(1'b0, 2'b11, 1'b0, 32'h0, 32'd0, lat, e, rd);
        check("err_size_err", {31'd0, e}, 32'd1);
        do_op(1'b1, 2'b10, 1'b0, 32'h1000, 32'h5555_5555, lat, e, rd);
        check("err_oor_err", {31'd0, e}, 32'd1);
        check("err_oor_str", str_cnt, 32'd0);
        check("err_oor_mem", mem[0], 32'h8000_F080);
        do_op(1'b1, 2'b10, 1'b0, 32'h2, 32'h6666_6666, lat, e, rd);
        check("err_sw_mis", {31'd0, e}, 32'd1);
        check("err_sw_mis_mem", mem[0], 32'h8000_F080);

        // reset during RMW_RD
        mem[2] = 32'hCAFE_F00D;
        @(negedge clk);
        zero_counts();
        we = 1'b1; size = 2'b00; cpu_addr = 32'h8; cpu_wdata = 32'h55; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("rmw_rd_state", {29'd0, dbg_state}, 32'd2);
        clr = 1'b1;
        @(posedge clk); #1;
        check("abort_state", {29'd0, dbg_state}, 32'd0);
        check("abort_outs", {28'd0, busy, done, err, ram_sel}, 32'd0);
        check("abort_ctl", {30'd0, ram_ld, ram_str}, 32'd0);
        check("abort_addr", {22'd0, ram_addr}, 32'd0);
        check("abort_wdata", ram_wdata, 32'd0);
        check("abort_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_str", str_cnt, 32'd0);
        do_op(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, lat, e, rd);
        check("abort_readback", rd, 32'hCAFE_F00D);

        // clr and req together: request dropped
        @(negedge clk);
        clr = 1'b1; req = 1'b1; we = 1'b0; size = 2'b10; cpu_addr = 32'h10;
        @(posedge clk); #1;
        clr = 1'b0; req = 1'b0;
        check("clr_req_state", {29'd0, dbg_state}, 32'd0);
        check("clr_req_busy", {31'd0, busy}, 32'd0);

        // req held high across a load
        @(negedge clk);
        zero_counts();
        we = 1'b0; size = 2'b10; sign_ext = 1'b0; cpu_addr = 32'h10; req = 1'b1;
        @(posedge clk); #1;
        check("hold_e1", {29'd0, dbg_state}, 32'd1);
        @(posedge clk); #1;
        check("hold_e2", {29'd0, dbg_state}, 32'd5);
        @(posedge clk); #1;
        check("hold_e3", {29'd0, dbg_state}, 32'd0);
        @(posedge clk); #1;
        check("hold_e4", {29'd0, dbg_state}, 32'd1);
        req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("hold_done_cnt", done_cnt, 32'd2);
        check("hold_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("never_ld_and_str", ovl_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
